// File: rtl/elastic_pipeline_pkg.sv
// Shared constants and helpers for the elastic +INCR pipeline.
package elastic_pipeline_pkg;

  localparam int DEF_WIDTH      = 5;
  localparam int DEF_NUM_STAGES = 5;
  localparam int DEF_INCR       = 1;

  // Stage contents at the default width; stages build the same layout at their own WIDTH.
  typedef struct packed {
    logic                 valid;
    logic                 wrap;
    logic [DEF_WIDTH-1:0] data;
  } stage_t;

  function automatic int occ_width(input int num_stages);
    return $clog2(num_stages + 1);
  endfunction

endpackage

// File: rtl/elastic_pipeline_if.sv
// Upstream and downstream valid/ready channels of the elastic pipeline.
// A transfer happens on a channel in any cycle where valid && rdy; valid never looks at rdy.
interface elastic_pipeline_if
  import elastic_pipeline_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic [WIDTH-1:0] input_val;
  logic             input_valid;
  logic             input_rdy;
  logic [WIDTH-1:0] output_val;
  logic             output_wrap;
  logic             output_valid;
  logic             output_rdy;

  modport master (
    output input_val, input_valid, output_rdy,
    input  input_rdy, output_val, output_wrap, output_valid
  );

  modport slave (
    input  input_val, input_valid, output_rdy,
    output input_rdy, output_val, output_wrap, output_valid
  );

endinterface

// File: rtl/elastic_pipeline_pipe_stage.sv
// One register stage: holds valid/wrap/data and adds INCR to whatever it loads.
module elastic_pipeline_pipe_stage
  import elastic_pipeline_pkg::*;
#(
  parameter int               WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] INCR  = WIDTH'(DEF_INCR)
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             flush_i,
  input  logic             load,
  input  logic             prev_valid,
  input  logic             prev_wrap,
  input  logic [WIDTH-1:0] prev_data,
  output logic             valid,
  output logic             wrap,
  output logic [WIDTH-1:0] data
);

  typedef struct packed {
    logic             valid;
    logic             wrap;
    logic [WIDTH-1:0] data;
  } stage_reg_t;

  stage_reg_t     q;
  logic [WIDTH:0] sum;

  assign sum = {1'b0, prev_data} + {1'b0, INCR};

  // Payload only moves with a real item, so bubbles never disturb the held data.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      q <= '0;
    end else if (flush_i) begin
      q.valid <= 1'b0;
    end else if (load) begin
      q.valid <= prev_valid;
      if (prev_valid) begin
        q.wrap <= prev_wrap | sum[WIDTH];
        q.data <= sum[WIDTH-1:0];
      end
    end
  end

  assign valid = q.valid;
  assign wrap  = q.wrap;
  assign data  = q.data;

endmodule

// File: rtl/elastic_pipeline.sv
// NUM_STAGES-deep valid/ready pipeline adding INCR per stage, with bubble collapsing,
// synchronous flush and a live occupancy count.
module elastic_pipeline
  import elastic_pipeline_pkg::*;
#(
  parameter int  WIDTH      = DEF_WIDTH,
  parameter int  NUM_STAGES = DEF_NUM_STAGES,
  parameter int  INCR       = DEF_INCR,
  localparam int OCC_W      = occ_width(NUM_STAGES)
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               flush_i,
  output logic [OCC_W-1:0]   occupancy_o,
  elastic_pipeline_if.slave  bus
);

  localparam logic [WIDTH-1:0] INCR_W = WIDTH'(INCR);

  logic [NUM_STAGES-1:0] v;
  logic [NUM_STAGES-1:0] w;
  logic [NUM_STAGES-1:0] adv;
  logic [WIDTH-1:0]      d [NUM_STAGES];
  logic                  push;

  // A stage may advance if the one ahead advances or it is itself a bubble.
  always_comb begin
    logic chain;
    adv   = '0;
    chain = bus.output_rdy;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      chain  = chain || !v[i];
      adv[i] = chain;
    end
  end

  assign bus.input_rdy = adv[0] && !flush_i;
  assign push          = bus.input_valid && bus.input_rdy;

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    logic             pv;
    logic             pw;
    logic [WIDTH-1:0] pd;

    if (i == 0) begin : g_head
      assign pv = push;
      assign pw = 1'b0;
      assign pd = bus.input_val;
    end else begin : g_body
      assign pv = v[i-1];
      assign pw = w[i-1];
      assign pd = d[i-1];
    end

    elastic_pipeline_pipe_stage #(
      .WIDTH (WIDTH),
      .INCR  (INCR_W)
    ) u_stage (
      .clk_i      (clk_i),
      .reset_ni   (reset_ni),
      .flush_i    (flush_i),
      .load       (adv[i]),
      .prev_valid (pv),
      .prev_wrap  (pw),
      .prev_data  (pd),
      .valid      (v[i]),
      .wrap       (w[i]),
      .data       (d[i])
    );
  end

  assign bus.output_valid = v[NUM_STAGES-1];
  assign bus.output_wrap  = w[NUM_STAGES-1];
  assign bus.output_val   = d[NUM_STAGES-1];

  always_comb begin
    occupancy_o = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      occupancy_o = occupancy_o + OCC_W'(v[i]);
    end
  end

endmodule
